// File: rtl/bram_rd_pkg.sv
// Shared types and sizing for the BRAM burst reader and its output FIFO.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry register FIFO with show-ahead output; push and pop may coincide when full.
module sync_fifo2
  import bram_rd_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem_reg [FIFO_DEPTH];
  logic                  rd_ptr_reg;
  logic                  wr_ptr_reg;
  logic [FIFO_CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: ;
      endcase
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/bram_burst_reader.sv
// Turns one (address, length) burst request into BRAM reads and a valid/ready
// output stream, buffering read data so backpressure never drops a word.
module bram_burst_reader
  import bram_rd_pkg::*;
#(
  parameter int LEN_DATA = 32,
  parameter int LEN_ADDR = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LEN_ADDR-1:0] req_addr,
  input  logic [LEN_ADDR-1:0] req_len,
  output logic                bram_en,
  output logic [LEN_ADDR-1:0] bram_addr,
  input  logic [LEN_DATA-1:0] bram_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  state_t                state_reg, state_next;
  logic [LEN_ADDR-1:0]   issue_addr_reg;
  logic [LEN_ADDR-1:0]   remain_reg;
  logic [LEN_ADDR-1:0]   last_addr_reg;
  logic                  inflight_reg;
  logic                  last_tag_reg;
  logic                  issue;
  logic                  pop;
  logic                  can_issue;
  logic                  is_last_issue;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_empty;
  logic [LEN_DATA:0]     fifo_dout;
  logic [FIFO_CNT_W:0]   occupancy;

  assign pop = out_valid & out_ready;

  // Words already owed to the FIFO after this cycle's pop; a read is only
  // launched when its data is guaranteed a slot two cycles from now.
  assign occupancy = (FIFO_CNT_W + 1)'(fifo_count)
                   + (FIFO_CNT_W + 1)'(inflight_reg)
                   - (FIFO_CNT_W + 1)'(pop);
  assign can_issue     = occupancy < (FIFO_CNT_W + 1)'(FIFO_DEPTH);
  assign is_last_issue = (remain_reg == '0);

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    unique case (state_reg)
      IDLE:  if (req_valid) state_next = ISSUE;
      ISSUE: begin
        if (can_issue) begin
          issue = 1'b1;
          if (is_last_issue) state_next = DRAIN;
        end
      end
      DRAIN: if (pop && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_addr_reg <= '0;
      remain_reg     <= '0;
      last_addr_reg  <= '0;
      inflight_reg   <= 1'b0;
      last_tag_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        issue_addr_reg <= req_addr;
        remain_reg     <= req_len;
      end else if (issue) begin
        issue_addr_reg <= issue_addr_reg + LEN_ADDR'(1);
        remain_reg     <= remain_reg - LEN_ADDR'(1);
        last_addr_reg  <= issue_addr_reg;
      end
      inflight_reg <= issue;
      last_tag_reg <= issue & is_last_issue;
    end
  end

  sync_fifo2 #(
    .WIDTH(LEN_DATA + 1)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (inflight_reg),
    .pop    (pop),
    .din    ({last_tag_reg, bram_dout}),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign bram_en   = issue;
  assign bram_addr = issue ? issue_addr_reg : last_addr_reg;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_dout[LEN_DATA-1:0];
  assign out_last  = fifo_dout[LEN_DATA];

endmodule

// File: doc/bram_burst_reader.md
Name: bram_burst_reader

Overview:
- Read-side client for the dual-port byte-write BRAM. It drives the BRAM read port (enable, address) and consumes its 1-cycle registered read data.
- Turns a single burst request (start address, beat count) into a valid/ready output stream with last-beat marking.
- Sits between the BRAM read port and stream consumers such as cache refill, DMA out, or debug dump.
- Absorbs backpressure without losing in-flight read data, and sustains one beat per cycle when the consumer is always ready.

Parameters:
- LEN_DATA, 32, data width in bits; must match the BRAM.
- LEN_ADDR, 8, address width; DEPTH = 2**LEN_ADDR words.

Ports:
- clk  in  1  single clock; also drives the BRAM read clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  LEN_ADDR  first word address.
- req_len  in  LEN_ADDR  beat count minus 1 (0 means 1 beat; all-ones means DEPTH beats).
- bram_en  out  1  to BRAM read enable.
- bram_addr  out  LEN_ADDR  to BRAM read address.
- bram_dout  in  LEN_DATA  from BRAM read data; valid the cycle after bram_en.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LEN_DATA  beat data.
- out_last  out  1  final beat of the burst.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset values (asynchronous, while resetn=0): state=IDLE, bram_en=0, bram_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, FIFO empty, in-flight flag=0. req_ready=1 one cycle after release.
- Reset mid-burst: the burst is aborted immediately, with no output beats after it. BRAM contents are untouched.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on req_valid&req_ready, latch addr into issue_addr and req_len into remain, then go to ISSUE.
  - ISSUE: issue one read per cycle when allowed. Each issue asserts bram_en=1 and bram_addr=issue_addr, increments issue_addr mod DEPTH (wrap 2**LEN_ADDR-1 to 0), and decrements remain. The issue that uses remain==0 is the last read, tagged last, and moves the FSM to DRAIN.
  - DRAIN: no reads. Return to IDLE in the cycle after the last beat handshakes.
- Issue condition: (fifo_count + inflight - pop) < 2, where pop = out_valid&out_ready. The FIFO can therefore never overflow, and full throughput holds at out_ready=1.
- inflight is set on the cycle bram_en=1 and is cleared the next cycle. On that next cycle, bram_dout and the latched last tag are pushed into the FIFO.
- bram_en=0 whenever no read is issued. bram_addr holds its last value when idle.
- Latency: request accepted in cycle T; first read issued in T+1; bram_dout valid in T+2; out_valid=1 in T+3.
- Sustained throughput: 1 beat/cycle with out_ready held high. An N-beat burst completes its last handshake at T+N+2.
- Stream rules:
  - out_data and out_last are stable while out_valid&!out_ready.
  - out_valid never drops without a handshake.
  - out_last=1 on exactly one beat per burst.
- Bubbles: out_ready low stalls issue after at most 2 buffered words; issue resumes the cycle a pop frees space.
- A request arriving while busy is not accepted (req_ready=0). Back-to-back bursts have a minimum of one IDLE cycle between them.
- Port-A writes to an address during the same cycle as its read return whatever the BRAM returns (old data). The block gives no coherence guarantee.

Decomposition:
- Package bram_rd_pkg: state enum (IDLE, ISSUE, DRAIN) and the FIFO depth constant 2.
- Sub-module sync_fifo2: 2-entry register FIFO, LEN_DATA+1 bits wide (data plus last). Ports: push, pop, din, dout, count, empty. Push and pop are allowed in the same cycle when full.

Test Plan:
- Preload ram[i]=i+0x100. Request addr=0x10, len=3, out_ready=1 -> out_valid from T+3; data 0x110..0x113 on consecutive cycles; out_last only on 0x113; req_ready high at T+7.
- Request addr=0xFE, len=3 (LEN_ADDR=8) -> bram_addr sequence FE, FF, 00, 01; data ram[FE], ram[FF], ram[0], ram[1].
- Request len=7 with out_ready toggling 1,0,0,1 repeatedly -> all 8 beats in order, none lost or duplicated; data stable while stalled; never more than 2 words buffered plus 1 in flight.
- Request len=0 -> exactly one beat with out_last=1; FSM passes ISSUE to DRAIN to IDLE.
- Pulse resetn low at the 3rd beat of a len=15 burst -> outputs at reset values immediately; no further beats. A new request addr=0 len=1 then completes normally.
- Request len=0xFF from addr 0 with out_ready=1 -> 256 beats in 256 consecutive cycles; out_last on beat 256; addresses wrap once to 0 on completion.
